hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage miniRV pipeline (IF, ID, EX, DM, WB). It merges three hazard sources into per-stage hold and flush controls:

- the load-use stall request from the forwarding unit;
- a taken branch or jump resolved in EX;
- a multi-cycle data-memory handshake in DM.

It also gates the PC redirect, enforces a memory-wait timeout and keeps stall/flush performance counters.

---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/perf_cnt.sv | 24 ++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared miniRV pipeline definitions: the sequencer FSM state, the default
// memory-wait timeout and the per-stage hold/flush control bundle.
package pipe_pkg;

    // Default limit on consecutive data-memory wait cycles before a forced release
    localparam int TIMEOUT_CYC_DEF = 64;

    // Legacy-compatible state encodings, wrapped by the enum below
    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    typedef enum logic [0:0] {
        RUN      = ST_RUN,
        MEM_WAIT = ST_MEM_WAIT
    } state_e;

    // Hold/flush controls for the pipeline registers, reused by the register stages
    typedef struct packed {
        logic keep_pc;
        logic keep_if_id;
        logic keep_id_ex;
        logic keep_ex_dm;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_dm_wb;
    } stage_ctrl_t;

    // Memory wait: freeze everything up to EX/DM and bubble DM/WB
    localparam stage_ctrl_t CTRL_MEM_WAIT = '{
        keep_pc: 1'b1, keep_if_id: 1'b1, keep_id_ex: 1'b1, keep_ex_dm: 1'b1,
        flush_if_id: 1'b0, flush_id_ex: 1'b0, flush_dm_wb: 1'b1
    };

    // Taken branch in EX: squash the two younger instructions
    localparam stage_ctrl_t CTRL_BRANCH = '{
        keep_pc: 1'b0, keep_if_id: 1'b0, keep_id_ex: 1'b0, keep_ex_dm: 1'b0,
        flush_if_id: 1'b1, flush_id_ex: 1'b1, flush_dm_wb: 1'b0
    };

    // Load-use: hold fetch/decode one cycle and insert a bubble into EX
    localparam stage_ctrl_t CTRL_LOAD_USE = '{
        keep_pc: 1'b1, keep_if_id: 1'b1, keep_id_ex: 1'b0, keep_ex_dm: 1'b0,
        flush_if_id: 1'b0, flush_id_ex: 1'b1, flush_dm_wb: 1'b0
    };

endpackage

// File: rtl/perf_cnt.sv
// Wrapping event counter with an increment enable.
module perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc_en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    // Count enabled cycles; natural overflow gives modulo 2^CNT_W wrap
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (inc_en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the five-stage miniRV pipeline. Merges the
// data-memory wait, EX branch redirect and load-use stall into per-stage
// hold/flush controls, with a memory-wait timeout and performance counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_i,
    input  logic             branch_ex_i,
    input  logic             dm_req_dm_i,
    input  logic             dm_ack_i,
    output logic             dm_req_o,
    output logic             redirect_en_o,
    output logic             keep_pc_o,
    output logic             keep_if_id_o,
    output logic             keep_id_ex_o,
    output logic             keep_ex_dm_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             flush_dm_wb_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             state_o
);

    // Wait counter only has to reach TIMEOUT_CYC-1
    localparam int               WAIT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    state_e            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              bus_err_reg, bus_err_next;

    logic              timeout;
    logic              mem_stall;
    stage_ctrl_t       ctrl;
    logic              redirect_en;

    // The counter is cleared in RUN, so a timeout can only occur while waiting
    assign timeout   = (state_reg == MEM_WAIT) && (wait_cnt_reg == WAIT_LAST);
    assign mem_stall = dm_req_dm_i & ~dm_ack_i & ~timeout;

    // Priority merge of the hazard sources into stage controls
    always_comb begin
        ctrl        = '0;
        redirect_en = 1'b0;
        if (mem_stall) begin
            // Branch and load-use stay frozen upstream until the wait releases
            ctrl = CTRL_MEM_WAIT;
        end else if (branch_ex_i) begin
            // A coincident load-use is dropped: its consumer is being squashed
            ctrl        = CTRL_BRANCH;
            redirect_en = 1'b1;
        end else if (load_use_i) begin
            ctrl = CTRL_LOAD_USE;
        end
    end

    // Next-state, wait-count and sticky error logic
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = '0;
        bus_err_next  = bus_err_reg | (timeout & dm_req_dm_i & ~dm_ack_i);
        case (state_reg)
            RUN: begin
                // A zero-wait access (ack with request) never leaves RUN
                if (mem_stall) begin
                    state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                // Leave on ack, timeout, or the request going away
                if (mem_stall) begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end else begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // State, wait counter and error flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            bus_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            bus_err_reg  <= bus_err_next;
        end
    end

    // Performance counters: index 0 counts stall cycles, index 1 redirects
    logic [1:0]       cnt_en;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_en[0] = ctrl.keep_pc;
    assign cnt_en[1] = redirect_en;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            perf_cnt #(
                .CNT_W (CNT_W)
            ) u_perf_cnt (
                .clk    (clk),
                .srst   (rst),
                .inc_en (cnt_en[gi]),
                .count  (cnt_val[gi])
            );
        end
    endgenerate

    assign dm_req_o      = dm_req_dm_i;
    assign redirect_en_o = redirect_en;
    assign keep_pc_o     = ctrl.keep_pc;
    assign keep_if_id_o  = ctrl.keep_if_id;
    assign keep_id_ex_o  = ctrl.keep_id_ex;
    assign keep_ex_dm_o  = ctrl.keep_ex_dm;
    assign flush_if_id_o = ctrl.flush_if_id;
    assign flush_id_ex_o = ctrl.flush_id_ex;
    assign flush_dm_wb_o = ctrl.flush_dm_wb;
    assign bus_err_o     = bus_err_reg;
    assign stall_cnt_o   = cnt_val[0];
    assign flush_cnt_o   = cnt_val[1];
    assign state_o       = state_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Each cycle's stimulus pushes the
// hand-computed expected outputs into a queue; a monitor on the falling
// edge pops and compares them against the DUT.
module tb_hazard_ctrl;

    localparam int CNT_W = 32;

    // Expected/observed output bundle; ctrl = {keep_pc, keep_if_id, keep_id_ex,
    // keep_ex_dm, flush_if_id, flush_id_ex, flush_dm_wb}
    typedef struct packed {
        logic [6:0]       ctrl;
        logic             redir;
        logic             st;
        logic             err;
        logic             dmreq;
        logic [CNT_W-1:0] scnt;
        logic [CNT_W-1:0] fcnt;
    } obs_t;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100010;
    localparam logic [6:0] BR   = 7'b0000110;
    localparam logic [6:0] MW   = 7'b1111001;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_use_i = 1'b0;
    logic             branch_ex_i = 1'b0;
    logic             dm_req_dm_i = 1'b0;
    logic             dm_ack_i = 1'b0;
    logic             dm_req_o;
    logic             redirect_en_o;
    logic             keep_pc_o;
    logic             keep_if_id_o;
    logic             keep_id_ex_o;
    logic             keep_ex_dm_o;
    logic             flush_if_id_o;
    logic             flush_id_ex_o;
    logic             flush_dm_wb_o;
    logic             bus_err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             state_o;

    int    checks   = 0;
    int    failures = 0;
    obs_t  exp_q  [$];
    string name_q [$];

    always #5 clk = ~clk;

    hazard_ctrl #(
        .TIMEOUT_CYC (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_use_i    (load_use_i),
        .branch_ex_i   (branch_ex_i),
        .dm_req_dm_i   (dm_req_dm_i),
        .dm_ack_i      (dm_ack_i),
        .dm_req_o      (dm_req_o),
        .redirect_en_o (redirect_en_o),
        .keep_pc_o     (keep_pc_o),
        .keep_if_id_o  (keep_if_id_o),
        .keep_id_ex_o  (keep_id_ex_o),
        .keep_ex_dm_o  (keep_ex_dm_o),
        .flush_if_id_o (flush_if_id_o),
        .flush_id_ex_o (flush_id_ex_o),
        .flush_dm_wb_o (flush_dm_wb_o),
        .bus_err_o     (bus_err_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o),
        .state_o       (state_o)
    );

    // Drive one cycle of inputs just after the edge and queue the expectation
    task automatic step(input string nm, input logic r, input logic lu, input logic br,
                        input logic req, input logic ack, input logic [6:0] ctrl,
                        input logic redir, input logic st, input logic err,
                        input int scnt, input int fcnt);
        obs_t e;
        @(posedge clk);
        #1;
        rst         = r;
        load_use_i  = lu;
        branch_ex_i = br;
        dm_req_dm_i = req;
        dm_ack_i    = ack;
        e.ctrl  = ctrl;
        e.redir = redir;
        e.st    = st;
        e.err   = err;
        e.dmreq = req;
        e.scnt  = CNT_W'(scnt);
        e.fcnt  = CNT_W'(fcnt);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: every cycle with a pending expectation is one transaction
    initial begin
        obs_t  got;
        obs_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                got.ctrl  = {keep_pc_o, keep_if_id_o, keep_id_ex_o, keep_ex_dm_o,
                             flush_if_id_o, flush_id_ex_o, flush_dm_wb_o};
                got.redir = redirect_en_o;
                got.st    = state_o;
                got.err   = bus_err_o;
                got.dmreq = dm_req_o;
                got.scnt  = stall_cnt_o;
                got.fcnt  = flush_cnt_o;
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL %s: got ctrl=%b redir=%b st=%b err=%b dmreq=%b scnt=%0d fcnt=%0d, want ctrl=%b redir=%b st=%b err=%b dmreq=%b scnt=%0d fcnt=%0d",
                             nm, got.ctrl, got.redir, got.st, got.err, got.dmreq, got.scnt, got.fcnt,
                             e.ctrl, e.redir, e.st, e.err, e.dmreq, e.scnt, e.fcnt);
                end else begin
                    $display("txn %0d %s ok ctrl=%b redir=%b st=%b err=%b scnt=%0d fcnt=%0d",
                             checks, nm, got.ctrl, got.redir, got.st, got.err, got.scnt, got.fcnt);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        //    name            rst lu br rq ak  ctrl  rd st er scnt fcnt
        step("reset",         1,  0, 0, 0, 0,  NONE, 0, 0, 0, 0,  0);
        step("idle0",         0,  0, 0, 0, 0,  NONE, 0, 0, 0, 0,  0);
        step("load_use",      0,  1, 0, 0, 0,  LU,   0, 0, 0, 0,  0);
        step("lu_after",      0,  0, 0, 0, 0,  NONE, 0, 0, 0, 1,  0);
        step("branch",        0,  0, 1, 0, 0,  BR,   1, 0, 0, 1,  0);
        step("br_after",      0,  0, 0, 0, 0,  NONE, 0, 0, 0, 1,  1);
        step("branch_lu",     0,  1, 1, 0, 0,  BR,   1, 0, 0, 1,  1);
        step("brlu_after",    0,  0, 0, 0, 0,  NONE, 0, 0, 0, 1,  2);
        step("wait3_c0",      0,  0, 0, 1, 0,  MW,   0, 0, 0, 1,  2);
        step("wait3_c1",      0,  0, 0, 1, 0,  MW,   0, 1, 0, 2,  2);
        step("wait3_c2",      0,  0, 0, 1, 0,  MW,   0, 1, 0, 3,  2);
        step("wait3_ack",     0,  0, 0, 1, 1,  NONE, 0, 1, 0, 4,  2);
        step("wait3_after",   0,  0, 0, 0, 0,  NONE, 0, 0, 0, 4,  2);
        step("zero_wait",     0,  0, 0, 1, 1,  NONE, 0, 0, 0, 4,  2);
        step("zw_after",      0,  0, 0, 0, 0,  NONE, 0, 0, 0, 4,  2);
        step("brwait_c0",     0,  0, 1, 1, 0,  MW,   0, 0, 0, 4,  2);
        step("brwait_c1",     0,  0, 1, 1, 0,  MW,   0, 1, 0, 5,  2);
        step("brwait_rel",    0,  0, 1, 1, 1,  BR,   1, 1, 0, 6,  2);
        step("brwait_after",  0,  0, 0, 0, 0,  NONE, 0, 0, 0, 6,  3);
        step("tmo_c0",        0,  0, 0, 1, 0,  MW,   0, 0, 0, 6,  3);
        step("tmo_c1",        0,  0, 0, 1, 0,  MW,   0, 1, 0, 7,  3);
        step("tmo_c2",        0,  0, 0, 1, 0,  MW,   0, 1, 0, 8,  3);
        step("tmo_c3",        0,  0, 0, 1, 0,  MW,   0, 1, 0, 9,  3);
        step("tmo_release",   0,  0, 0, 1, 0,  NONE, 0, 1, 0, 10, 3);
        step("tmo_err",       0,  0, 0, 0, 0,  NONE, 0, 0, 1, 10, 3);
        step("tmo_sticky",    0,  0, 0, 0, 0,  NONE, 0, 0, 1, 10, 3);
        step("rst_pulse",     1,  0, 0, 0, 0,  NONE, 0, 0, 1, 10, 3);
        step("post_rst",      0,  0, 0, 0, 0,  NONE, 0, 0, 0, 0,  0);
        step("mwrst_c0",      0,  0, 0, 1, 0,  MW,   0, 0, 0, 0,  0);
        step("mwrst_c1",      0,  0, 0, 1, 0,  MW,   0, 1, 0, 1,  0);
        step("mwrst_rst",     1,  0, 0, 1, 0,  MW,   0, 1, 0, 2,  0);
        step("mwrst_after",   0,  0, 0, 0, 0,  NONE, 0, 0, 0, 0,  0);

        // Give the monitor a bounded window to drain the queue
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
